// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared definitions for the LED pattern generator.
//   MODE_W        width of the mode field
//   mode_e        pattern selector (chase, bounce, count, bar)
//   mode_init_one 1 when a mode starts from the single-LSB pattern, 0 when it
//                 starts from all-zero
package led_pattern_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BAR    = 2'd3
    } mode_e;

    function automatic logic mode_init_one(input mode_e m);
        return (m == MODE_CHASE) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler: free-running divider producing a base tick.
//   i_clk  clock, rising edge
//   rst    synchronous active-low reset (counter to 0)
//   tick   high for one cycle while the count sits at DIV-1
module led_tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (!rst)      cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: steps an LED pattern (chase, bounce, count, bar) at a
// programmable rate derived from a base tick of TICK_HZ.
//   i_clk   clock, rising edge
//   rst     synchronous active-low reset
//   i_mode  requested pattern (0 chase, 1 bounce, 2 count, 3 bar)
//   i_dir   0 toward MSB / up, 1 toward LSB / down
//   i_hold  1 freezes the pattern (tick and rate counters keep running)
//   i_rate  step period in ticks, minus 1
//   o_leds  current pattern
//   o_step  one-cycle pulse in the cycle o_leds takes a new value
//   o_mode  mode currently displayed
// Build option: LED_PATTERN_BOUNCE_EN enables bounce mode; without it a
// request for bounce is treated as chase and reported as mode 0.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CLK_FREQ = 25000000,
    parameter int TICK_HZ  = 100
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic             i_hold,
    input  logic [3:0]       i_rate,
    output logic [WIDTH-1:0] o_leds,
    output logic             o_step,
    output logic [1:0]       o_mode
);

    localparam int DIV = CLK_FREQ / TICK_HZ;

    logic tick;

    led_tick_prescaler #(.DIV(DIV)) u_presc (
        .i_clk (i_clk),
        .rst   (rst),
        .tick  (tick)
    );

    // ">=" rather than "==" so a rate lowered below the current count
    // fires on the very next tick instead of wrapping through 15.
    logic [3:0] rate_cnt;
    logic       step_evt;

    assign step_evt = tick && (rate_cnt >= i_rate);

    always_ff @(posedge i_clk) begin
        if (!rst)          rate_cnt <= '0;
        else if (step_evt) rate_cnt <= '0;
        else if (tick)     rate_cnt <= rate_cnt + 4'd1;
    end

    mode_e req_mode;
`ifdef LED_PATTERN_BOUNCE_EN
    assign req_mode = mode_e'(i_mode);
`else
    assign req_mode = (i_mode == MODE_BOUNCE) ? MODE_CHASE : mode_e'(i_mode);
`endif

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] leds_d;
    logic             step_d;

`ifdef LED_PATTERN_BOUNCE_EN
    // bdn_q: 1 = next bounce move is toward the LSB. An endpoint always
    // forces the move away from it, so the lit bit never falls off the edge.
    logic bdn_q, bdn_d, go_up;
    assign go_up = bdn_q ? o_leds[0] : ~o_leds[WIDTH-1];
`endif

    always_comb begin
        leds_d = o_leds;
        mode_d = mode_q;
        step_d = 1'b0;
`ifdef LED_PATTERN_BOUNCE_EN
        bdn_d  = bdn_q;
`endif
        if (step_evt && !i_hold) begin
            step_d = 1'b1;
            if (req_mode != mode_q) begin
                // Mode entry only loads the start pattern; no advance.
                mode_d = req_mode;
                leds_d = mode_init_one(req_mode) ? WIDTH'(1) : '0;
`ifdef LED_PATTERN_BOUNCE_EN
                bdn_d  = i_dir;
`endif
            end else begin
                case (mode_q)
                    MODE_CHASE:
                        leds_d = i_dir ? {o_leds[0], o_leds[WIDTH-1:1]}
                                       : {o_leds[WIDTH-2:0], o_leds[WIDTH-1]};
`ifdef LED_PATTERN_BOUNCE_EN
                    MODE_BOUNCE: begin
                        leds_d = go_up ? (o_leds << 1) : (o_leds >> 1);
                        if (leds_d[WIDTH-1]) bdn_d = 1'b1;
                        else if (leds_d[0])  bdn_d = 1'b0;
                        else                 bdn_d = ~go_up;
                    end
`endif
                    MODE_COUNT:
                        leds_d = i_dir ? o_leds - WIDTH'(1) : o_leds + WIDTH'(1);
                    MODE_BAR:
                        if (&o_leds)    leds_d = '0;
                        else if (i_dir) leds_d = {1'b1, o_leds[WIDTH-1:1]};
                        else            leds_d = {o_leds[WIDTH-2:0], 1'b1};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            o_leds <= WIDTH'(1);
            mode_q <= MODE_CHASE;
            o_step <= 1'b0;
`ifdef LED_PATTERN_BOUNCE_EN
            bdn_q  <= 1'b0;
`endif
        end else begin
            o_leds <= leds_d;
            mode_q <= mode_d;
            o_step <= step_d;
`ifdef LED_PATTERN_BOUNCE_EN
            bdn_q  <= bdn_d;
`endif
        end
    end

    assign o_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed plus randomized bench for led_pattern_gen
// (WIDTH=8, DIV=10). A behavioural model tracks edges since reset, ticks
// since the last step, and the pattern as integers / a bit position.
module tb_led_pattern_gen;

    localparam int W   = 8;
    localparam int DIV = 10;

    logic         i_clk  = 1'b0;
    logic         rst    = 1'b0;
    logic [1:0]   i_mode = 2'd0;
    logic         i_dir  = 1'b0;
    logic         i_hold = 1'b0;
    logic [3:0]   i_rate = 4'd0;
    logic [W-1:0] o_leds;
    logic         o_step;
    logic [1:0]   o_mode;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int m_cyc, m_ticks, m_leds, m_mode, m_pos;
    bit m_step, m_dn;

    always #5 i_clk = ~i_clk;

    led_pattern_gen #(.WIDTH(W), .CLK_FREQ(100), .TICK_HZ(10)) dut (
        .i_clk  (i_clk),
        .rst    (rst),
        .i_mode (i_mode),
        .i_dir  (i_dir),
        .i_hold (i_hold),
        .i_rate (i_rate),
        .o_leds (o_leds),
        .o_step (o_step),
        .o_mode (o_mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge of the model, using the inputs as they stand at the edge.
    task automatic model_update();
        int em;
        bit fire, up;
        em = int'(i_mode);
`ifndef LED_PATTERN_BOUNCE_EN
        if (em == 1) em = 0;
`endif
        if (!rst) begin
            m_cyc = 0; m_ticks = 0; m_leds = 1; m_mode = 0; m_step = 0; m_dn = 0;
        end else begin
            m_cyc++;
            fire = 0;
            if (m_cyc % DIV == 0) begin
                if (m_ticks >= int'(i_rate)) begin fire = 1; m_ticks = 0; end
                else m_ticks++;
            end
            m_step = fire && !i_hold;
            if (m_step) begin
                if (em != m_mode) begin
                    m_mode = em;
                    m_leds = (em < 2) ? 1 : 0;
                    m_pos  = 0;
                    m_dn   = i_dir;
                end else begin
                    case (m_mode)
                        0: m_leds = i_dir ? (m_leds / 2 + (m_leds % 2) * 128)
                                          : ((m_leds * 2) % 256 + m_leds / 128);
                        1: begin
                            up     = m_dn ? (m_pos == 0) : (m_pos != W - 1);
                            m_pos  = up ? m_pos + 1 : m_pos - 1;
                            m_dn   = (m_pos == W - 1) ? 1'b1 : (m_pos == 0) ? 1'b0 : !up;
                            m_leds = 1 << m_pos;
                        end
                        2: m_leds = (m_leds + (i_dir ? 255 : 1)) % 256;
                        default: m_leds = (m_leds == 255) ? 0 :
                                          i_dir ? (m_leds / 2 + 128) : ((m_leds * 2 + 1) % 256);
                    endcase
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        model_update();
        #1;
        chk("leds", 32'(o_leds), 32'(m_leds));
        chk("step", 32'(o_step), 32'(m_step));
        chk("mode", 32'(o_mode), 32'(m_mode));
    endtask

    // Runs until the model steps (bounded), returning the cycles taken.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!m_step && n < 400);
        chk("step_seen", 32'(o_step), 32'd1);
    endtask

    initial begin
        int n, hs, first;

        // reset
        rst = 1'b0;
        repeat (3) cyc();
        chk("rst_leds", 32'(o_leds), 32'h01);
        chk("rst_mode", 32'(o_mode), 32'd0);
        chk("rst_step", 32'(o_step), 32'd0);

        // chase up, first pulse DIV cycles after release
        rst = 1'b1;
        first = -1;
        for (int i = 1; i <= 40 && first < 0; i++) begin
            cyc();
            if (o_step) first = i;
        end
        chk("first_step", first, 10);
        chk("chase_first", 32'(o_leds), 32'h02);
        repeat (90) cyc();

        // bounce (or chase alias without the build option)
        i_mode = 2'd1;
        repeat (250) cyc();

        // count down from zero, then reverse at FD
        i_mode = 2'd2; i_dir = 1'b1;
        for (int i = 0; i < 500 && !(m_mode == 2 && m_leds == 8'hFD); i++) cyc();
        chk("cnt_at_fd", 32'(o_leds), 32'hFD);
        i_dir = 1'b0;
        wait_step(n);
        chk("cnt_dir_switch", 32'(o_leds), 32'hFE);

        // bar at rate 2, then a 100-cycle hold
        i_mode = 2'd3; i_rate = 4'd2;
        wait_step(n);
        chk("bar_entry", 32'(o_leds), 32'h00);
        wait_step(n);
        chk("bar_period", n, 30);
        chk("bar_1", 32'(o_leds), 32'h01);
        wait_step(n);
        chk("bar_3", 32'(o_leds), 32'h03);
        repeat (150) cyc();
        i_hold = 1'b1;
        hs = 0;
        repeat (100) begin
            cyc();
            hs += int'(o_step);
        end
        chk("hold_steps", hs, 0);
        i_hold = 1'b0;
        repeat (200) cyc();

        // mode switch mid-chase at 10
        i_mode = 2'd0; i_rate = 4'd0; i_dir = 1'b0;
        for (int i = 0; i < 2000 && !(m_mode == 0 && m_leds == 8'h10); i++) cyc();
        chk("chase_at_10", 32'(o_leds), 32'h10);
        i_mode = 2'd2;
        wait_step(n);
        chk("sw_leds", 32'(o_leds), 32'h00);
        chk("sw_mode", 32'(o_mode), 32'd2);
        chk("sw_step", 32'(o_step), 32'd1);

        // reset mid-run, then first-step latency with a nonzero rate
        repeat (23) cyc();
        rst = 1'b0;
        cyc();
        chk("midrst_leds", 32'(o_leds), 32'h01);
        chk("midrst_mode", 32'(o_mode), 32'd0);
        i_rate = 4'($urandom_range(1, 5));
        rst = 1'b1;
        wait_step(n);
        chk("rst_latency", n, (int'(i_rate) + 1) * DIV);

        // randomized phase
        repeat (4000) begin
            if ($urandom_range(0, 79) == 0)  i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) i_dir  = ~i_dir;
            if ($urandom_range(0, 99) == 0)  i_rate = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0)  i_hold = ~i_hold;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
